uart_receiver: RTL and testbench

- UART receive stage: consumes the asynchronous RsRx line and the shared oversampling baud tick.
- Produces an 8-bit byte plus a one-cycle ready strobe for downstream consumers: the seven-segment interpreter and the VGA text path.
- Sits directly downstream of baudrate_gen and the RsRx pin, inside the receiver top.
- 8N1 framing, LSB first, 16x oversampling, mid-bit sampling.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_ff.sv | 30 +++
 rtl/uart_receiver.sv | 140 ++++++++++++++
 tb/tb_uart_receiver.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and types: frame geometry defaults (also used by the
// sender side and baudrate_gen), receiver state encoding and counter widths.
package uart_pkg;

  // Baud ticks per bit period and payload bits per frame (8N1 framing).
  localparam int OVERSAMPLE  = 16;
  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;

  // Counter widths derived from the defaults above.
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  // Receiver frame-tracking states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for an asynchronous single-bit input.
// The reset value is a parameter so an idle-high line (UART, PS/2) can
// come out of reset looking idle instead of presenting a false edge.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the flop chain; oldest sample is the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      for (int i = STAGES - 1; i > 0; i--) begin
        chain[i] <= chain[i-1];
      end
      chain[0] <= d;
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 8N1, LSB first, oversampled with mid-bit sampling.
// All decisions are taken on the synchronized line and only on clk edges
// that carry a baud tick; without a tick everything holds except the
// one-cycle dataRdy / frameErr strobes, which always fall.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = uart_pkg::OVERSAMPLE,
  parameter int DATA_BITS   = uart_pkg::DATA_BITS,
  parameter int SYNC_STAGES = uart_pkg::SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud,
  input  logic                 RsRx,
  output logic [DATA_BITS-1:0] data,
  output logic                 dataRdy,
  output logic                 frameErr,
  output logic                 busy
);

  localparam int TICK_BITS = $clog2(OVERSAMPLE);
  localparam int CNT_BITS  = $clog2(DATA_BITS + 1);

  // The start bit is confirmed half a bit period after detection; every
  // later sample is a full bit period after the previous one. The counter
  // is compared against "last tick" values so it never needs to hold
  // OVERSAMPLE itself.
  localparam logic [TICK_BITS-1:0] HALF_LAST = TICK_BITS'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_BITS-1:0] FULL_LAST = TICK_BITS'(OVERSAMPLE - 1);
  localparam logic [CNT_BITS-1:0]  BIT_LAST  = CNT_BITS'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state;
  logic [TICK_BITS-1:0] tick_cnt;
  logic [CNT_BITS-1:0]  bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;

  // Line idles high, so the synchronizer presets to 1 to avoid a false start.
  sync_ff #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk  (clk),
    .reset(reset),
    .d    (RsRx),
    .q    (rx_s)
  );

  // Frame FSM with counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data      <= '0;
      dataRdy   <= 1'b0;
      frameErr  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      dataRdy  <= 1'b0;
      frameErr <= 1'b0;
      if (baud) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state    <= START;
              tick_cnt <= '0;
              busy     <= 1'b1;
            end
          end

          START: begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                // Line went back high before mid start bit: a glitch.
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          DATA: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt  <= '0;
              // LSB arrives first, so new bits enter at the top.
              shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
                state <= STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          STOP: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              if (rx_s) begin
                // Leaving mid stop bit lets a back-to-back start be caught.
                data    <= shift_reg;
                dataRdy <= 1'b1;
                state   <= IDLE;
                busy    <= 1'b0;
              end else begin
                frameErr <= 1'b1;
                state    <= BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          BREAK: begin
            // Wait out a held-low line so it reports only one error.
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end

          default: begin
            state    <= IDLE;
            tick_cnt <= '0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus random
// frames, compared against a frame-level model (what bytes / errors a
// sequence of serial frames should yield, and when).
module tb_uart_receiver;

  localparam int OS       = 16;
  localparam int DB       = 8;
  localparam int BAUD_DIV = 16;
  // Ticks from the line falling to the stop sample: one tick to detect the
  // start bit, half a bit to its centre, then nine full bits.
  localparam int LATENCY  = 1 + OS / 2 + OS * (DB + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          baud;
  logic          RsRx;
  logic [DB-1:0] data;
  logic          dataRdy;
  logic          frameErr;
  logic          busy;

  uart_receiver #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .baud    (baud),
    .RsRx    (RsRx),
    .data    (data),
    .dataRdy (dataRdy),
    .frameErr(frameErr),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Baud generator, freezable.
  bit freeze = 1'b0;
  int div_cnt = 0;
  initial begin
    baud = 1'b0;
    forever begin
      @(negedge clk);
      if (freeze) begin
        baud = 1'b0;
      end else begin
        baud    = (div_cnt == BAUD_DIV - 1);
        div_cnt = (div_cnt == BAUD_DIV - 1) ? 0 : div_cnt + 1;
      end
    end
  end

  int tick_total = 0;
  always @(posedge clk) begin
    if (baud) tick_total <= tick_total + 1;
  end

  // Passive monitor: records every strobe and any pulse-shape violation.
  logic [DB-1:0] got_arr [0:255];
  int rdy_cnt = 0;
  int rdy_tick = 0;
  int ferr_seen = 0;
  int shape_bad = 0;
  logic rdy_prev = 1'b0;
  logic ferr_prev = 1'b0;
  always @(negedge clk) begin
    if (dataRdy) begin
      got_arr[rdy_cnt[7:0]] = data;
      rdy_cnt  = rdy_cnt + 1;
      rdy_tick = tick_total;
      if (rdy_prev || frameErr) shape_bad = shape_bad + 1;
    end
    if (frameErr) begin
      ferr_seen = ferr_seen + 1;
      if (ferr_prev) shape_bad = shape_bad + 1;
    end
    rdy_prev  = dataRdy;
    ferr_prev = frameErr;
  end

  // Reference model state.
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] data_model = '0;
  int ferr_exp = 0;
  int rd_idx = 0;
  int fall_tick = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Hold the line at a level for n baud ticks; returns on a negedge.
  task automatic send_level(input logic lvl, input int n);
    RsRx = lvl;
    repeat (n) @(posedge clk iff baud);
    @(negedge clk);
  endtask

  // Send one 8N1 frame; optionally freeze the baud tick mid data bit.
  task automatic send_frame(input logic [DB-1:0] b, input logic stop_bit, input int freeze_bit);
    int rdy_snap, ferr_snap;
    logic [DB-1:0] data_snap;
    fall_tick = tick_total;
    send_level(1'b0, OS);
    for (int i = 0; i < DB; i++) begin
      if (i == freeze_bit) begin
        send_level(b[i], OS / 2);
        rdy_snap  = rdy_cnt;
        ferr_snap = ferr_seen;
        data_snap = data;
        chk("freeze_busy_before", 32'(busy), 32'd1);
        freeze = 1'b1;
        repeat (500) @(negedge clk);
        chk("freeze_busy_during", 32'(busy), 32'd1);
        chk("freeze_no_rdy", rdy_cnt, rdy_snap);
        chk("freeze_no_ferr", ferr_seen, ferr_snap);
        chk("freeze_data_hold", 32'(data), 32'(data_snap));
        freeze = 1'b0;
        send_level(b[i], OS - OS / 2);
      end else begin
        send_level(b[i], OS);
      end
    end
    send_level(stop_bit, OS);
    if (stop_bit) begin
      exp_q.push_back(b);
      data_model = b;
      chk("latency", rdy_tick - fall_tick, LATENCY);
    end else begin
      ferr_exp++;
    end
    $display("frame sent 0x%02h stop=%0b", b, stop_bit);
  endtask

  // Compare everything observed since the last call with the model.
  task automatic verify(input string tag);
    logic [DB-1:0] e;
    chk({tag, "_rdy_count"}, rdy_cnt - rd_idx, exp_q.size());
    while (rd_idx < rdy_cnt && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_byte"}, 32'(got_arr[rd_idx[7:0]]), 32'(e));
      $display("rx byte 0x%02h expected 0x%02h", got_arr[rd_idx[7:0]], e);
      rd_idx++;
    end
    rd_idx = rdy_cnt;
    exp_q.delete();
    chk({tag, "_ferr_count"}, ferr_seen, ferr_exp);
    chk({tag, "_data"}, 32'(data), 32'(data_model));
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_pulse_shape"}, shape_bad, 0);
  endtask

  initial begin
    logic [DB-1:0] a5;
    logic [DB-1:0] rb;
    logic          rok;
    reset = 1'b1;
    RsRx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data", 32'(data), 32'd0);
    chk("reset_rdy", 32'(dataRdy), 32'd0);
    chk("reset_ferr", 32'(frameErr), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(posedge clk iff baud);
    @(negedge clk);
    send_level(1'b1, 4);

    // Short low glitch: START must abort without output.
    send_level(1'b0, 4);
    chk("glitch_busy", 32'(busy), 32'd1);
    send_level(1'b1, 12);
    verify("glitch");

    // Plain frame 0x41 with latency check.
    send_frame(8'h41, 1'b1, -1);
    send_level(1'b1, 8);
    verify("f41");

    // Bad stop bit followed by a held-low break, then a good frame.
    send_frame(8'h41, 1'b0, -1);
    send_level(1'b0, 40);
    send_level(1'b1, 4);
    verify("break");
    send_frame(8'h5A, 1'b1, -1);
    send_level(1'b1, 4);
    verify("f5a");

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    send_level(1'b1, 4);
    verify("b2b");

    // Reset after data bit 3 of 0xA5, then a clean frame.
    a5 = 8'hA5;
    send_level(1'b0, OS);
    for (int i = 0; i < 4; i++) send_level(a5[i], OS);
    chk("rst_mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    RsRx  = 1'b1;
    @(negedge clk);
    chk("rst_mid_data", 32'(data), 32'd0);
    chk("rst_mid_rdy", 32'(dataRdy), 32'd0);
    chk("rst_mid_ferr", 32'(frameErr), 32'd0);
    chk("rst_mid_busy0", 32'(busy), 32'd0);
    reset = 1'b0;
    data_model = '0;
    send_level(1'b1, 4);
    send_frame(8'h33, 1'b1, -1);
    send_level(1'b1, 4);
    verify("rst_mid");

    // Baud tick frozen for 500 clks in the middle of data bit 3.
    send_frame(8'hC3, 1'b1, 3);
    send_level(1'b1, 4);
    verify("freeze");

    // Random frames, some with bad stop bits, random idle gaps.
    for (int n = 0; n < 8; n++) begin
      rb  = DB'($urandom_range(0, 255));
      rok = ($urandom_range(0, 3) != 0);
      send_frame(rb, rok, -1);
      if (!rok) begin
        send_level(1'b0, $urandom_range(0, 30));
        send_level(1'b1, 1 + $urandom_range(0, 4));
      end else if ($urandom_range(0, 1) == 1) begin
        send_level(1'b1, $urandom_range(1, 20));
      end
    end
    send_level(1'b1, 4);
    verify("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
